// File: rtl/imem_access_ctrl_pkg.sv
// Shared encodings for the instruction-memory access controller.
// Opcode constants are also consumed by the control unit.
package imem_ctrl_pkg;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_F_ISSUE = 2'd1;
  localparam logic [1:0] S_F_RESP  = 2'd2;
  localparam logic [1:0] S_LOAD    = 2'd3;

  localparam logic [7:0] OP_NOP    = 8'd41;
  localparam logic [7:0] OP_ENDOP  = 8'd42;
  localparam logic [7:0] OP_LOADIM = 8'd33;

  function automatic logic [15:0] pad_byte(input logic [7:0] b);
    return {8'h00, b};
  endfunction

endpackage

// File: rtl/imem_access_ctrl_load_counter.sv
// Address register and load byte counter with a terminal-count flag.
// The address can be loaded from a fetch or load base, then stepped.
module imem_load_counter #(
  parameter int unsigned DEPTH = 191
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        addr_ld_i,
  input  logic [15:0] addr_val_i,
  input  logic        cnt_clr_i,
  input  logic        inc_i,
  output logic [15:0] addr_o,
  output logic [15:0] count_o,
  output logic        tc_o
);

  logic [15:0] addr_q, addr_d;
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    addr_d = addr_q;
    if (addr_ld_i) begin
      addr_d = addr_val_i;
    end else if (inc_i) begin
      addr_d = addr_q + 16'd1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      cnt_q  <= '0;
    end else begin
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign addr_o  = addr_q;
  assign count_o = cnt_q;
  assign tc_o    = (addr_q == 16'(DEPTH - 1));

endmodule

// File: rtl/imem_access_ctrl.sv
// Single owner of the instruction RAM port: arbitrates CPU fetches
// against the byte-stream program loader.
module imem_access_ctrl
  import imem_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH      = 191,
  parameter logic [15:0] LD_BASE    = 16'd0,
  parameter logic [7:0]  NOP_OPCODE = OP_NOP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_fetch_req,
  input  logic [15:0] cpu_pc,
  output logic [15:0] cpu_instr,
  output logic        cpu_instr_valid,
  output logic        cpu_addr_err,
  output logic        cpu_stall,
  input  logic        ld_start,
  input  logic        ld_valid,
  input  logic [7:0]  ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic        ld_busy,
  output logic [15:0] ld_count,
  output logic        ld_overflow,
  output logic        mem_write_en,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_instr_in,
  input  logic [15:0] mem_instr_out
);

  logic [1:0]  state_q, state_d;
  logic        range_err_q, range_err_d;
  logic        ovf_q, ovf_d;
  logic        addr_ld, cnt_clr, tc;
  logic [15:0] addr_val, addr_q;
  logic        in_load, in_resp, beat;

  assign in_load = (state_q == S_LOAD);
  assign in_resp = (state_q == S_F_RESP);
  assign beat    = in_load & ld_valid;

  always_comb begin
    state_d     = state_q;
    range_err_d = range_err_q;
    ovf_d       = ovf_q;
    addr_ld     = 1'b0;
    addr_val    = cpu_pc;
    cnt_clr     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // A pending load wins over a fetch request.
        if (ld_start) begin
          state_d  = S_LOAD;
          addr_ld  = 1'b1;
          addr_val = LD_BASE;
          cnt_clr  = 1'b1;
          ovf_d    = 1'b0;
        end else if (cpu_fetch_req) begin
          state_d     = S_F_ISSUE;
          addr_ld     = 1'b1;
          range_err_d = (cpu_pc >= 16'(DEPTH));
        end
      end
      S_F_ISSUE: state_d = S_F_RESP;
      S_F_RESP:  state_d = S_IDLE;
      S_LOAD: begin
        if (beat) begin
          if (ld_last) begin
            state_d = S_IDLE;
          end else if (tc) begin
            ovf_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      range_err_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      range_err_q <= range_err_d;
      ovf_q       <= ovf_d;
    end
  end

  imem_load_counter #(
    .DEPTH(DEPTH)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .addr_ld_i (addr_ld),
    .addr_val_i(addr_val),
    .cnt_clr_i (cnt_clr),
    .inc_i     (beat),
    .addr_o    (addr_q),
    .count_o   (ld_count),
    .tc_o      (tc)
  );

  assign cpu_instr       = range_err_q ? pad_byte(NOP_OPCODE)
                                       : mem_instr_out;
  assign cpu_instr_valid = in_resp;
  assign cpu_addr_err    = in_resp & range_err_q;
  assign cpu_stall       = in_load;
  assign ld_ready        = in_load;
  assign ld_busy         = in_load;
  assign ld_overflow     = ovf_q;
  assign mem_write_en    = beat;
  assign mem_addr        = addr_q;
  assign mem_instr_in    = pad_byte(ld_data);

endmodule

// File: tb/tb_imem_access_ctrl.sv
// Randomized bench for imem_access_ctrl with a behavioural RAM image
// model; the instruction RAM itself is emulated here.
module tb_imem_access_ctrl;

  localparam int unsigned DEPTH = 191;
  localparam logic [7:0]  NOP   = 8'd41;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_fetch_req;
  logic [15:0] cpu_pc;
  logic [15:0] cpu_instr;
  logic        cpu_instr_valid;
  logic        cpu_addr_err;
  logic        cpu_stall;
  logic        ld_start;
  logic        ld_valid;
  logic [7:0]  ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        ld_busy;
  logic [15:0] ld_count;
  logic        ld_overflow;
  logic        mem_write_en;
  logic [15:0] mem_addr;
  logic [15:0] mem_instr_in;
  logic [15:0] mem_instr_out;

  logic        bk_we;
  logic [7:0]  bk_addr;
  logic [15:0] bk_data;
  logic [15:0] ram [0:255];
  logic [15:0] ref_mem [0:DEPTH-1];
  logic [7:0]  ld_bytes [$];
  int          we_cnt = 0;
  int          n_chk = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  imem_access_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .cpu_fetch_req  (cpu_fetch_req),
    .cpu_pc         (cpu_pc),
    .cpu_instr      (cpu_instr),
    .cpu_instr_valid(cpu_instr_valid),
    .cpu_addr_err   (cpu_addr_err),
    .cpu_stall      (cpu_stall),
    .ld_start       (ld_start),
    .ld_valid       (ld_valid),
    .ld_data        (ld_data),
    .ld_last        (ld_last),
    .ld_ready       (ld_ready),
    .ld_busy        (ld_busy),
    .ld_count       (ld_count),
    .ld_overflow    (ld_overflow),
    .mem_write_en   (mem_write_en),
    .mem_addr       (mem_addr),
    .mem_instr_in   (mem_instr_in),
    .mem_instr_out  (mem_instr_out)
  );

  always @(posedge clk) begin
    if (bk_we) begin
      ram[bk_addr] <= bk_data;
    end else if (mem_write_en && mem_addr < 16'd256) begin
      ram[mem_addr[7:0]] <= mem_instr_in;
    end
    mem_instr_out <= (mem_addr < 16'd256) ? ram[mem_addr[7:0]]
                                          : 16'hDEAD;
    if (mem_write_en) we_cnt <= we_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic check_ram(input string tag);
    int bad = 0;
    for (int i = 0; i < int'(DEPTH); i++)
      if (ram[i] !== ref_mem[i]) bad++;
    chk(tag, 32'(bad), 32'd0);
  endtask

  task automatic do_fetch(input logic [15:0] pc);
    int lat;
    logic [15:0] exp;
    @(negedge clk);
    cpu_pc = pc;
    cpu_fetch_req = 1'b1;
    @(negedge clk);
    cpu_fetch_req = 1'b0;
    chk("f_early", 32'(cpu_instr_valid), 32'd0);
    lat = 1;
    while (!cpu_instr_valid && lat < 6) begin
      @(negedge clk);
      lat++;
    end
    exp = (pc < 16'(DEPTH)) ? ref_mem[pc] : {8'h00, NOP};
    chk("f_lat", 32'(lat), 32'd2);
    chk("f_instr", 32'(cpu_instr), 32'(exp));
    chk("f_err", 32'(cpu_addr_err), 32'(pc >= 16'(DEPTH)));
    chk("f_stall", 32'(cpu_stall), 32'd0);
    @(negedge clk);
    chk("f_1cyc", 32'(cpu_instr_valid), 32'd0);
  endtask

  // Model: bytes land at consecutive addresses until ld_last or the
  // RAM is full; anything offered after that is refused.
  task automatic do_load(input int n, input bit with_last,
                         input bit hold_req);
    int acc = 0;
    bit done = 1'b0;
    bit exp_ovf = 1'b0;
    logic [7:0] d;
    @(negedge clk);
    ld_start = 1'b1;
    cpu_fetch_req = hold_req;
    @(negedge clk);
    ld_start = 1'b0;
    chk("l_busy", 32'(ld_busy), 32'd1);
    chk("l_cnt0", 32'(ld_count), 32'd0);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        ld_valid = 1'b0;
        #1;
        chk("l_gap_we", 32'(mem_write_en), 32'd0);
        @(negedge clk);
      end
      d = (ld_bytes.size() != 0) ? ld_bytes.pop_front()
                                 : 8'($urandom);
      ld_valid = 1'b1;
      ld_data  = d;
      ld_last  = with_last && (i == n - 1);
      #1;
      chk("l_ready", 32'(ld_ready), 32'(!done));
      chk("l_we", 32'(mem_write_en), 32'(!done));
      chk("l_stall", 32'(cpu_stall), 32'(!done));
      chk("l_novalid", 32'(cpu_instr_valid), 32'd0);
      if (!done) begin
        chk("l_din", 32'(mem_instr_in), {24'h0, d});
        chk("l_addr", 32'(mem_addr), 32'(acc));
        ref_mem[acc] = {8'h00, d};
        acc++;
        if (ld_last) begin
          done = 1'b1;
        end else if (acc == int'(DEPTH)) begin
          done = 1'b1;
          exp_ovf = 1'b1;
        end
      end
      @(negedge clk);
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    #1;
    chk("l_end_busy", 32'(ld_busy), 32'd0);
    chk("l_count", 32'(ld_count), 32'(acc));
    chk("l_ovf", 32'(ld_overflow), 32'(exp_ovf));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int w0;
    int vcnt;
    rst = 1'b1;
    cpu_fetch_req = 1'b0;
    cpu_pc = '0;
    ld_start = 1'b0;
    ld_valid = 1'b0;
    ld_data = '0;
    ld_last = 1'b0;
    bk_we = 1'b0;
    bk_addr = '0;
    bk_data = '0;

    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      bk_we = 1'b1;
      bk_addr = 8'(i);
      bk_data = (i == 5) ? 16'd12 : 16'($urandom);
      if (i < int'(DEPTH)) ref_mem[i] = bk_data;
    end
    @(negedge clk);
    bk_we = 1'b0;
    @(negedge clk);
    chk("rst_cnt", 32'(ld_count), 32'd0);
    chk("rst_ovf", 32'(ld_overflow), 32'd0);
    chk("rst_busy", 32'(ld_busy), 32'd0);
    chk("rst_ready", 32'(ld_ready), 32'd0);
    chk("rst_stall", 32'(cpu_stall), 32'd0);
    chk("rst_valid", 32'(cpu_instr_valid), 32'd0);
    chk("rst_err", 32'(cpu_addr_err), 32'd0);
    chk("rst_we", 32'(mem_write_en), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    rst = 1'b0;

    w0 = we_cnt;
    do_fetch(16'd5);
    chk("t1_nowrite", 32'(we_cnt), 32'(w0));

    ld_bytes.push_back(8'd33);
    ld_bytes.push_back(8'd1);
    ld_bytes.push_back(8'd41);
    do_load(3, 1'b1, 1'b0);
    check_ram("t2_ram");

    cpu_pc = 16'd1;
    ld_bytes.push_back(8'd33);
    ld_bytes.push_back(8'd42);
    do_load(2, 1'b1, 1'b1);
    lat = 0;
    while (!cpu_instr_valid && lat < 6) begin
      @(negedge clk);
      lat++;
    end
    cpu_fetch_req = 1'b0;
    chk("t3_lat", 32'(lat), 32'd2);
    chk("t3_instr", 32'(cpu_instr), 32'(ref_mem[1]));
    @(negedge clk);

    w0 = we_cnt;
    do_fetch(16'd200);
    do_fetch(16'(DEPTH));
    do_fetch(16'(DEPTH - 1));
    chk("t4_nowrite", 32'(we_cnt), 32'(w0));
    check_ram("t4_ram");

    do_load(192, 1'b0, 1'b0);
    check_ram("t5_ram");

    @(negedge clk);
    ld_start = 1'b1;
    @(negedge clk);
    ld_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1'b1;
      ld_data = 8'($urandom);
      ref_mem[i] = {8'h00, ld_data};
      @(negedge clk);
    end
    ld_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("t6_busy", 32'(ld_busy), 32'd0);
    chk("t6_cnt", 32'(ld_count), 32'd0);
    chk("t6_stall", 32'(cpu_stall), 32'd0);
    chk("t6_ovf", 32'(ld_overflow), 32'd0);
    rst = 1'b0;
    check_ram("t6_ram");

    cpu_pc = 16'd7;
    cpu_fetch_req = 1'b1;
    @(negedge clk);
    cpu_fetch_req = 1'b0;
    rst = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rst = 1'b0;
      if (cpu_instr_valid) vcnt++;
    end
    chk("rst_fetch_novalid", 32'(vcnt), 32'd0);

    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 2) == 0)
        do_load(int'($urandom_range(1, 12)), 1'b1, 1'b0);
      else
        do_fetch(16'($urandom_range(0, 255)));
    end
    check_ram("rand_ram");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
